// File: rtl/rptr_empty_ctrl.sv
// rtl/rptr_empty_ctrl.sv - async FIFO read pointer, empty/almost-empty flags, fill level and flush
// Optional underflow checker compiled in with RPTR_UNDERFLOW_CHK_EN.
module rptr_empty_ctrl #(
  parameter int ADDRSIZE = 4
) (
  input  logic                rclk_i,
  input  logic                rrst_n_i,
  input  logic                ren,
  input  logic                flush,
  input  logic [ADDRSIZE:0]   wptr_sync2_rdclk,
  input  logic [ADDRSIZE:0]   ae_thresh,
  output logic [ADDRSIZE-1:0] rd_addr,
  output logic [ADDRSIZE:0]   rptr_g,
  output logic                fifo_empty,
  output logic                fifo_almost_empty,
  output logic [ADDRSIZE:0]   rd_level
`ifdef RPTR_UNDERFLOW_CHK_EN
  ,
  output logic                underflow
`endif
);

  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] rbin_next;
  logic [ADDRSIZE:0] rgray_next;
  logic [ADDRSIZE:0] lvl_next;
  logic              rinc;

  // XOR prefix from the MSB down
  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign wbin = gray2bin(wptr_sync2_rdclk);
  assign rinc = ren & ~fifo_empty & ~flush;

  // Flush jumps the read pointer onto the write pointer, dropping everything visible
  always_comb begin
    rbin_next = rbin;
    if (flush) begin
      rbin_next = wbin;
    end else begin
      rbin_next = rbin + {{ADDRSIZE{1'b0}}, rinc};
    end
  end

  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign lvl_next   = wbin - rbin_next;
  assign rd_addr    = rbin[ADDRSIZE-1:0];

  always_ff @(posedge rclk_i or negedge rrst_n_i) begin
    if (!rrst_n_i) begin
      rbin              <= '0;
      rptr_g            <= '0;
      rd_level          <= '0;
      fifo_empty        <= 1'b1;
      fifo_almost_empty <= 1'b1;
    end else begin
      rbin              <= rbin_next;
      rptr_g            <= rgray_next;
      rd_level          <= lvl_next;
      fifo_empty        <= (lvl_next == '0);
      fifo_almost_empty <= (lvl_next <= ae_thresh);
    end
  end

`ifdef RPTR_UNDERFLOW_CHK_EN
  // Sticky until flush or reset
  always_ff @(posedge rclk_i or negedge rrst_n_i) begin
    if (!rrst_n_i) begin
      underflow <= 1'b0;
    end else if (flush) begin
      underflow <= 1'b0;
    end else if (ren && fifo_empty) begin
      underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// tb/tb_rptr_empty_ctrl.sv - scoreboard bench for rptr_empty_ctrl against a counter-based FIFO model
module tb_rptr_empty_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ren;
  logic       flush;
  logic [4:0] wptr;
  logic [4:0] ae_thresh;
  logic [3:0] rd_addr;
  logic [4:0] rptr_g;
  logic       fifo_empty;
  logic       fifo_almost_empty;
  logic [4:0] rd_level;
`ifdef RPTR_UNDERFLOW_CHK_EN
  logic       underflow;
`endif

  rptr_empty_ctrl #(.ADDRSIZE(4)) dut (
    .rclk_i            (clk),
    .rrst_n_i          (rst_n),
    .ren               (ren),
    .flush             (flush),
    .wptr_sync2_rdclk  (wptr),
    .ae_thresh         (ae_thresh),
    .rd_addr           (rd_addr),
    .rptr_g            (rptr_g),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .rd_level          (rd_level)
`ifdef RPTR_UNDERFLOW_CHK_EN
    ,
    .underflow         (underflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int gray;
    int empty;
    int ae;
    int lvl;
    int uf;
    bit gchk;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: total entries written and read, as plain integers
  int wr_cnt = 0;
  int rd_cnt = 0;
  int m_level = 0;
  int m_uf = 0;
  bit skip_g = 1'b1;

  function automatic int to_gray(input int b);
    int m;
    m = b & 31;
    return (m >> 1) ^ m;
  endfunction

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Called at a negedge: drive inputs, advance the model for the coming edge, queue expectation
  task automatic cycle(input logic r, input logic f);
    exp_t e;
    ren   = r;
    flush = f;
    wptr  = 5'(to_gray(wr_cnt));
    if (f) begin
      rd_cnt = wr_cnt;
      m_uf   = 0;
    end else if (r && m_level != 0) begin
      rd_cnt++;
    end else if (r) begin
      m_uf = 1;
    end
    m_level = wr_cnt - rd_cnt;
    e.addr  = rd_cnt & 15;
    e.gray  = to_gray(rd_cnt);
    e.empty = (m_level == 0) ? 1 : 0;
    e.ae    = (m_level <= int'(ae_thresh)) ? 1 : 0;
    e.lvl   = m_level;
    e.uf    = m_uf;
    e.gchk  = !f && !skip_g;
    skip_g  = 1'b0;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_empty"}, int'(fifo_empty), 1);
    chk({tag, "_ae"}, int'(fifo_almost_empty), 1);
    chk({tag, "_level"}, int'(rd_level), 0);
    chk({tag, "_rptr_g"}, int'(rptr_g), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
`ifdef RPTR_UNDERFLOW_CHK_EN
    chk({tag, "_underflow"}, int'(underflow), 0);
`endif
  endtask

  // Monitor: one expectation per clock edge
  initial begin
    logic [4:0] prev_g;
    exp_t e;
    prev_g = '0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd_addr", int'(rd_addr), e.addr);
        chk("rptr_g", int'(rptr_g), e.gray);
        chk("fifo_empty", int'(fifo_empty), e.empty);
        chk("almost_empty", int'(fifo_almost_empty), e.ae);
        chk("rd_level", int'(rd_level), e.lvl);
        chk("level_in_range", int'(rd_level <= 5'd16), 1);
`ifdef RPTR_UNDERFLOW_CHK_EN
        chk("underflow", int'(underflow), e.uf);
`endif
        if (e.gchk) chk("gray_single_step", int'($countones(prev_g ^ rptr_g) <= 1), 1);
        prev_g = rptr_g;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    ren       = 1'b0;
    flush     = 1'b0;
    wptr      = '0;
    ae_thresh = 5'd2;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Write visibility and drain
    wr_cnt = 5;
    cycle(0, 0);
    repeat (3) cycle(1, 0);
    repeat (2) cycle(1, 0);

    // Reads while empty
    repeat (3) cycle(1, 0);
    cycle(0, 1);
    cycle(0, 0);

    // Wrap-around with the writer one entry ahead
    wr_cnt++;
    cycle(0, 0);
    for (int i = 0; i < 40; i++) begin
      wr_cnt++;
      cycle(1, 0);
    end
    cycle(1, 0);

    // Flush beats a simultaneous read at level 9
    wr_cnt += 9;
    cycle(0, 0);
    cycle(1, 1);
    cycle(1, 0);

    // Threshold edges
    ae_thresh = 5'd0;
    wr_cnt++;
    cycle(0, 0);
    ae_thresh = 5'd16;
    wr_cnt += 15;
    cycle(0, 0);
    ae_thresh = 5'd2;
    cycle(0, 0);
    cycle(0, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic f;
      if (wr_cnt - rd_cnt < 16 && $urandom_range(1, 0) == 1) wr_cnt++;
      r = ($urandom_range(1, 0) == 1);
      f = ($urandom_range(19, 0) == 0);
      if ($urandom_range(31, 0) == 0) ae_thresh = 5'($urandom_range(16, 0));
      cycle(r, f);
    end

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_reset");
    wr_cnt = 0;
    rd_cnt = 0;
    m_level = 0;
    m_uf = 0;
    skip_g = 1'b1;
    wptr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (wr_cnt - rd_cnt < 16 && $urandom_range(2, 0) != 0) wr_cnt++;
      cycle(($urandom_range(1, 0) == 1), 1'b0);
    end

    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
